// File: rtl/kbd_matrix_sync.sv
// PET PIA1 keyboard-matrix intercept: the Pi host loads per-row key bitmaps, the CPU scans them via PORTA/PORTB.
// Optional build macro KBD_STICKY_EN latches short presses until the CPU has scanned the row STICKY_READS times.
module kbd_matrix_sync #(
  parameter int unsigned ROWS         = 10,
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROW_SEL_BITS = 4,
  parameter logic [15:0] BASE_ADDR    = 16'hE800,
  parameter int unsigned STICKY_READS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             pi_addr,
  input  logic [COLS-1:0]         pi_data,
  input  logic                    pi_write_strobe,
  input  logic [1:0]              bus_addr,
  input  logic [7:0]              bus_data_in,
  input  logic                    bus_rw_b,
  input  logic                    pia1_enabled_in,
  input  logic                    io_select,
  input  logic                    cpu_write_strobe,
  output logic [COLS-1:0]         kbd_data_out,
  output logic                    kbd_enable
);

  localparam logic [1:0]      PORTA    = 2'd0;
  localparam logic [1:0]      PORTB    = 2'd2;
  localparam logic [COLS-1:0] ALL_ONES = '1;

  if (ROWS < 1 || ROWS > 16 || STICKY_READS < 1 || STICKY_READS > 15) begin : g_bad_cfg
    $error("kbd_matrix_sync: ROWS or STICKY_READS out of range");
  end

  // Strobe history for edge detection
  logic pi_wr_prev_q, pi_wr_prev_d;
  logic wr_a_prev_q,  wr_a_prev_d;
  logic rd_b_prev_q,  rd_b_prev_d;

  logic [COLS-1:0]         matrix_q [ROWS];
  logic [COLS-1:0]         matrix_d [ROWS];
  logic [ROW_SEL_BITS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0]         kbd_data_q, kbd_data_d;
  logic                    kbd_enable_q, kbd_enable_d;

`ifdef KBD_STICKY_EN
  localparam logic [3:0] STICKY_THR = 4'(STICKY_READS);
  logic [COLS-1:0] sticky_q [ROWS];
  logic [COLS-1:0] sticky_d [ROWS];
  logic [3:0]      cnt_q    [ROWS];
  logic [3:0]      cnt_d    [ROWS];
  logic [COLS-1:0] new_press_c;
`endif

  logic            writing_port_a_c, reading_port_b_c;
  logic            pi_commit_c, porta_commit_c, capture_c;
  logic [15:0]     pi_off_c;
  logic [COLS-1:0] sel_row_c;
  logic            unused_c;

  assign writing_port_a_c = cpu_write_strobe && pia1_enabled_in && (bus_addr == PORTA);
  assign reading_port_b_c = io_select && bus_rw_b && pia1_enabled_in && (bus_addr == PORTB);
  assign pi_commit_c      = pi_wr_prev_q && !pi_write_strobe;
  assign porta_commit_c   = wr_a_prev_q && !writing_port_a_c;
  assign capture_c        = reading_port_b_c && !rd_b_prev_q;
  // Offset wraps for addresses below BASE_ADDR, so one compare per row covers both bounds
  assign pi_off_c         = pi_addr - BASE_ADDR;
  assign unused_c         = ^bus_data_in;

  always_comb begin
    pi_wr_prev_d = pi_write_strobe;
    wr_a_prev_d  = writing_port_a_c;
    rd_b_prev_d  = reading_port_b_c;
    row_sel_d    = row_sel_q;
    kbd_data_d   = kbd_data_q;
    sel_row_c    = ALL_ONES;
    for (int r = 0; r < int'(ROWS); r++) begin
      matrix_d[r] = matrix_q[r];
    end
`ifdef KBD_STICKY_EN
    new_press_c = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      sticky_d[r] = sticky_q[r];
      cnt_d[r]    = cnt_q[r];
    end
`endif

    // Capture reads pre-update state: old row_sel, old matrix
    for (int r = 0; r < int'(ROWS); r++) begin
      if (32'(row_sel_q) == 32'(r)) begin
`ifdef KBD_STICKY_EN
        sel_row_c = matrix_q[r] & ~sticky_q[r];
`else
        sel_row_c = matrix_q[r];
`endif
      end
    end

    for (int r = 0; r < int'(ROWS); r++) begin
`ifdef KBD_STICKY_EN
      // Release once host has let go and the CPU has seen the press enough times
      if (cnt_q[r] >= STICKY_THR) begin
        sticky_d[r] = sticky_q[r] & ~matrix_q[r];
      end
      if (capture_c && (32'(row_sel_q) == 32'(r)) && (cnt_q[r] != 4'hF)) begin
        cnt_d[r] = cnt_q[r] + 4'd1;
      end
`endif
      if (pi_commit_c && (32'(pi_off_c) == 32'(r))) begin
        matrix_d[r] = pi_data;
`ifdef KBD_STICKY_EN
        new_press_c = matrix_q[r] & ~pi_data;
        if (|new_press_c) begin
          sticky_d[r] = sticky_d[r] | new_press_c;
          cnt_d[r]    = 4'd0;
        end
`endif
      end
    end

    if (porta_commit_c) begin
      row_sel_d = bus_data_in[ROW_SEL_BITS-1:0];
    end
    if (capture_c) begin
      kbd_data_d = sel_row_c;
    end
    kbd_enable_d = reading_port_b_c && (kbd_data_d != ALL_ONES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pi_wr_prev_q <= 1'b0;
      wr_a_prev_q  <= 1'b0;
      rd_b_prev_q  <= 1'b0;
      row_sel_q    <= '0;
      kbd_data_q   <= ALL_ONES;
      kbd_enable_q <= 1'b0;
      for (int r = 0; r < int'(ROWS); r++) begin
        matrix_q[r] <= ALL_ONES;
`ifdef KBD_STICKY_EN
        sticky_q[r] <= '0;
        cnt_q[r]    <= 4'd0;
`endif
      end
    end else begin
      pi_wr_prev_q <= pi_wr_prev_d;
      wr_a_prev_q  <= wr_a_prev_d;
      rd_b_prev_q  <= rd_b_prev_d;
      row_sel_q    <= row_sel_d;
      kbd_data_q   <= kbd_data_d;
      kbd_enable_q <= kbd_enable_d;
      for (int r = 0; r < int'(ROWS); r++) begin
        matrix_q[r] <= matrix_d[r];
`ifdef KBD_STICKY_EN
        sticky_q[r] <= sticky_d[r];
        cnt_q[r]    <= cnt_d[r];
`endif
      end
    end
  end

  assign kbd_data_out = kbd_data_q;
  assign kbd_enable   = kbd_enable_q;

endmodule
